disp_chan_sched: RTL
====================

Name: disp_chan_sched

Overview:
Channel scheduler for the 8-channel 32-bit display multiplexer. It drives the multiplexer's 3-bit channel select (Test) and enable (EN).
- Auto mode: cycles through the enabled channels, dwelling on each for a fixed period.
- Manual mode: next/previous button edges step the channel.
- Sits between the debounced button/switch inputs and the display mux, in the top-level display path.

Parameters:
DWELL_CYC, 50000000, clock cycles each channel is shown in auto mode (≥2; the bench uses 4).
CNT_W, 26, dwell counter width; must satisfy 2^CNT_W ≥ DWELL_CYC.

Ports:
clk  in  1  system clock, all state on rising edge.
rst  in  1  asynchronous, active-high reset.
ch_mask  in  8  bit i=1 → channel i eligible for display.
auto  in  1  level; 1=auto-scan, 0=manual.
freeze  in  1  level; 1 suspends auto advance, counter holds.
step  in  1  debounced level; rising edge = advance to next enabled channel.
back  in  1  debounced level; rising edge = go to previous enabled channel.
Test  out  3  registered channel select to mux.
EN  out  1  registered display enable to mux.
chg  out  1  registered one-cycle pulse, high in the first cycle a new Test value is presented.

Behaviour:
- Reset (async, rst=1): Test=0, EN=0, chg=0, dwell counter=0, step/back edge registers=0.
- Edge detect: step_q/back_q registers; edge = in & ~in_q. Step/back are synchronous, already debounced.
- NEXT(c): lowest-distance enabled channel scanning c+1, c+2, … with mod-8 wrap; returns c if c is the only enabled channel.
- PREV(c): same search, scanning downward with wrap.
- States:
  - EMPTY: ch_mask==0. EN=0, Test holds, counter=0. On ch_mask≠0, go to ACTIVE next cycle:
    - EN=1.
    - Test = Test if ch_mask[Test], else NEXT(Test).
    - chg=1 if Test changed.
  - ACTIVE: EN=1.
- ACTIVE per-cycle priority, highest first:
  1. ch_mask==0 → EMPTY, EN=0 next cycle, chg=0.
  2. ch_mask[Test]==0 (current channel dropped) → Test=NEXT(Test), counter=0, chg=1.
  3. Step edge and back edge together → no change, both ignored.
  4. Step edge → Test=NEXT(Test), counter=0.
  5. Back edge → Test=PREV(Test), counter=0.
  6. auto & ~freeze & counter==DWELL_CYC-1 → Test=NEXT(Test), counter=0.
  7. Otherwise: counter+1 if auto & ~freeze; held if freeze; 0 if ~auto.
- chg=1 only when the registered Test value actually changes. A step with a single enabled channel gives no chg; counter still clears.
- Latency: edge sampled at clock edge n → new Test and chg=1 visible after edge n+1. Auto advance occurs exactly DWELL_CYC cycles after the previous change.
- Manual steps are honoured in auto mode and while frozen.
- Dropping auto to 0 clears the counter. Raising it starts a full dwell.
- rst asserted mid-dwell or mid-pulse returns all outputs to reset values immediately.
- Counter is never compared beyond DWELL_CYC-1; no wrap-around occurs.

Optional Feature:
DISP_SCHED_LED_EN.
- Defined: adds output led_out[7:0], registered, = one-hot(Test) when EN=1, else 0; updates in the same cycle as Test.
- Undefined: port and logic absent. All other behaviour is identical.

Test Plan:
1. Reset: rst=1 with ch_mask=8'hFF → Test=0, EN=0, chg=0. Release, then next cycle → EN=1, Test=0, chg=0.
2. Auto scan: DWELL_CYC=4, ch_mask=8'b1010_0100, auto=1 → Test sequence 2,5,7,2 with 4-cycle spacing; chg one-cycle pulse at each change.
3. Manual:
   - auto=0, ch_mask=8'h81, Test=0: step pulse → Test=7 next cycle; step pulse → 0 (wrap).
   - back pulse → 7.
   - step and back rising together → no change, chg=0.
4. Freeze: auto=1, freeze=1 for 10 cycles at counter=2 → Test unchanged. Release → advance after 2 more cycles.
5. Mask change:
   - Test=3, clear ch_mask[3] with ch_mask=8'h18 → Test=4 next cycle, chg=1.
   - ch_mask=0 → EN=0. Restore 8'h01 → EN=1, Test=0.
6. Async reset mid-dwell: rst pulsed between clock edges at counter=2 → outputs reset without waiting for a clock edge. With DISP_SCHED_LED_EN defined, led_out=0 during reset and 8'h01 after EN=1, Test=0.

Source files
------------

// File: rtl/disp_chan_sched_if.sv
// Control/status bundle between the button/switch front end and the display-mux channel scheduler.
// Optional DISP_SCHED_LED_EN adds the led_out one-hot channel indicator.
interface disp_chan_sched_if;
  logic [7:0] ch_mask;
  logic       auto;
  logic       freeze;
  logic       step;
  logic       back;
  logic [2:0] Test;
  logic       EN;
  logic       chg;
`ifdef DISP_SCHED_LED_EN
  logic [7:0] led_out;
`endif

  modport master (
    output ch_mask, auto, freeze, step, back,
`ifdef DISP_SCHED_LED_EN
    input  led_out,
`endif
    input  Test, EN, chg
  );

  modport slave (
    input  ch_mask, auto, freeze, step, back,
`ifdef DISP_SCHED_LED_EN
    output led_out,
`endif
    output Test, EN, chg
  );
endinterface

// File: rtl/disp_chan_sched.sv
// Channel scheduler for the 8-channel display mux: auto dwell scan or manual step/back.
// Define DISP_SCHED_LED_EN to add the registered one-hot led_out indicator.
module disp_chan_sched #(
  parameter int unsigned DWELL_CYC = 50000000,
  parameter int unsigned CNT_W     = 26
) (
  input logic               clk,
  input logic               rst,
  disp_chan_sched_if.slave  bus
);

  typedef enum logic {S_EMPTY, S_ACTIVE} state_t;

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_test, w_test_nxt;
  logic             r_chg;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_step_q, r_back_q;
  logic             w_step_edge, w_back_edge;
  logic [2:0]       w_next, w_prev;

  // Nearest enabled channel in the given direction with mod-8 wrap; c itself if it is the only one.
  function automatic logic [2:0] f_scan(input logic [2:0] c, input logic [7:0] m, input logic up);
    logic [2:0] res;
    logic [2:0] cand;
    logic       found;
    res   = c;
    found = 1'b0;
    for (int unsigned i = 1; i < 8; i++) begin
      cand = up ? c + 3'(i) : c - 3'(i);
      if (m[cand] && !found) begin
        res   = cand;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign w_step_edge = bus.step & ~r_step_q;
  assign w_back_edge = bus.back & ~r_back_q;
  assign w_next      = f_scan(r_test, bus.ch_mask, 1'b1);
  assign w_prev      = f_scan(r_test, bus.ch_mask, 1'b0);

  always_comb begin
    w_state_nxt = r_state;
    w_test_nxt  = r_test;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_EMPTY: begin
        w_cnt_nxt = '0;
        if (bus.ch_mask != '0) begin
          w_state_nxt = S_ACTIVE;
          if (!bus.ch_mask[r_test]) w_test_nxt = w_next;
        end
      end
      default: begin
        if (bus.ch_mask == '0) begin
          w_state_nxt = S_EMPTY;
          w_cnt_nxt   = '0;
        end else if (!bus.ch_mask[r_test]) begin
          w_test_nxt = w_next;
          w_cnt_nxt  = '0;
        end else if (w_step_edge && w_back_edge) begin
          // Simultaneous edges cancel: channel and dwell count both hold.
          w_cnt_nxt = r_cnt;
        end else if (w_step_edge) begin
          w_test_nxt = w_next;
          w_cnt_nxt  = '0;
        end else if (w_back_edge) begin
          w_test_nxt = w_prev;
          w_cnt_nxt  = '0;
        end else if (!bus.auto) begin
          w_cnt_nxt = '0;
        end else if (!bus.freeze) begin
          if (r_cnt == CNT_W'(DWELL_CYC - 1)) begin
            w_test_nxt = w_next;
            w_cnt_nxt  = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_EMPTY;
      r_test   <= '0;
      r_chg    <= 1'b0;
      r_cnt    <= '0;
      r_step_q <= 1'b0;
      r_back_q <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_test   <= w_test_nxt;
      r_chg    <= (w_test_nxt != r_test);
      r_cnt    <= w_cnt_nxt;
      r_step_q <= bus.step;
      r_back_q <= bus.back;
    end
  end

  assign bus.Test = r_test;
  assign bus.EN   = (r_state == S_ACTIVE);
  assign bus.chg  = r_chg;

`ifdef DISP_SCHED_LED_EN
  logic [7:0] r_led;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_led <= '0;
    else     r_led <= (w_state_nxt == S_ACTIVE) ? (8'd1 << w_test_nxt) : '0;
  end

  assign bus.led_out = r_led;
`endif

endmodule
